ram_burst_reader: RTL and testbench
===================================

# ram_burst_reader

Initiator side of the Gelato RAM word-read protocol. Accepts a burst request (byte base address, word count), issues sequential 32-bit word reads to the RAM slave, and streams the returned words through a small FIFO to a valid/ready consumer. It sits between fetch/load units and the RAM and decouples consumer backpressure from RAM latency.

## Interface
- ADDR_WIDTH, 32, byte-address width; addresses wrap modulo 2^ADDR_WIDTH
- DATA_WIDTH, 32, word width (4 bytes, little-endian as delivered by the RAM)
- LEN_WIDTH, 8, width of the burst word count
- FIFO_DEPTH, 4, output buffer entries (power of two, at least 2)

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global run enable; 0 freezes the block
- req_valid  in  1  burst request present
- req_ready  out  1  request accepted when req_valid && req_ready at a clock edge
- req_addr  in  ADDR_WIDTH  byte base address (any alignment is passed through unchanged)
- req_len  in  LEN_WIDTH  number of words to read
- ram_req  out  1  read strobe to RAM
- ram_addr  out  ADDR_WIDTH  byte address of the current word
- ram_data  in  DATA_WIDTH  read data, valid when ram_done=1
- ram_done  in  1  RAM completion for the current ram_addr
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer accepts the head
- out_data  out  DATA_WIDTH  FIFO head word
- out_last  out  1  head is the final word of its burst
- busy  out  1  burst in progress (state FETCH)

## Operation
- States: IDLE, FETCH.
- IDLE: req_ready = rdy. On acceptance with req_len != 0: cur_addr <- req_addr, remaining <- req_len, go FETCH. With req_len == 0: accepted, no RAM access, no output, stay IDLE.
- FETCH: req_ready = 0, busy = 1. ram_req = rdy && (fifo_count < FIFO_DEPTH). ram_addr = cur_addr.
- Word completion is ram_req && ram_done at a clock edge:
  - push {ram_data, last = (remaining == 1)} into the FIFO
  - cur_addr <- cur_addr + 4
  - remaining <- remaining - 1
  - when remaining was 1, go IDLE.
- While ram_done = 0, ram_req and ram_addr are held stable.
- FIFO: out_valid = rdy && (fifo_count != 0). A pop occurs when out_valid && out_ready. Push and pop in the same cycle leave the count unchanged and are legal when full, but ram_req is still gated on count < FIFO_DEPTH, so a push never occurs when the FIFO is full.
- A new burst may be accepted while older words remain in the FIFO. Order is preserved, and out_last delimits the bursts.
- rdy = 0:
  - req_ready, ram_req and out_valid are forced to 0
  - ram_done and out_ready are ignored
  - all registers hold their values; when rdy returns to 1, operation resumes exactly where it stopped.
- Address arithmetic wraps: 0xFFFF_FFFC + 4 gives 0x0000_0000.
- Reset values: state IDLE, ram_req 0, ram_addr 0, cur_addr 0, remaining 0, fifo_count 0, out_valid 0, out_data 0, out_last 0, busy 0. req_ready follows rdy immediately after reset.
- Reset asserted mid-burst: the burst is abandoned, the FIFO is emptied, outputs return to their reset values asynchronously, and no words are emitted after release.

## Timing
- Request accepted at edge E0. ram_req is high in cycle E0..E1. With ram_done = 1 combinational, the word is captured at E1 and out_valid is high in the following cycle.
- Sustained throughput is 1 word/cycle when ram_done is held high and out_ready = 1.
- For a burst of N words with zero-wait RAM and no backpressure, FETCH lasts N cycles and req_ready returns high in the cycle after the last capture.
- A RAM stall of k cycles (ram_done low) adds exactly k cycles.
- With out_ready = 0, ram_req drops in the cycle after the FIFO reaches FIFO_DEPTH entries. It rises again in the cycle after the first pop.

## Test plan
- Basic burst: req_addr=0x100, req_len=3, RAM words 0x11111111/0x22222222/0x33333333. Required response: ram_addr sequence 0x100, 0x104, 0x108; out_data in that order; out_last only on 0x33333333; busy for 3 cycles.
- Backpressure: req_len=8, out_ready=0 for 10 cycles, then 1. Required response: exactly FIFO_DEPTH=4 ram_req completions before the stall; all 8 words delivered in order with no loss or duplication.
- RAM wait states: ram_done low for 2 cycles on the second word. Required response: ram_addr holds 0x104 for 3 cycles; output order is unchanged.
- Wrap and zero length: req_addr=0xFFFFFFF8, req_len=3. Required response: ram_addr sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000. Then req_len=0: accepted, no ram_req, no output.
- rdy freeze: drop rdy for 3 cycles mid-burst. Required response: ram_req, out_valid and req_ready are 0 during the freeze; the burst resumes at the same ram_addr with no skipped words.
- Reset mid-burst: assert rst after 2 of 6 words. Required response: all outputs go to reset values without waiting for a clock edge; after release, out_valid stays 0 and req_ready = 1.

Source files
------------

// File: rtl/ram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : ram_burst_reader
// Brief    : Burst read initiator for the Gelato RAM word-read protocol.
//            Issues sequential word reads and buffers results in a small FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ram_burst_reader #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  ram_req,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_data,
  input  logic                  ram_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int                    PTR_W        = $clog2(FIFO_DEPTH);
  localparam int                    CNT_W        = PTR_W + 1;
  localparam logic [CNT_W-1:0]      C_DEPTH      = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]      C_CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0]      C_PTR_ONE    = PTR_W'(1);
  localparam logic [ADDR_WIDTH-1:0] C_WORD_BYTES = ADDR_WIDTH'(4);
  localparam logic [LEN_WIDTH-1:0]  C_LEN_ONE    = LEN_WIDTH'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   cur_addr_q;
  logic [LEN_WIDTH-1:0]    remaining_q;
  logic [DATA_WIDTH-1:0]   mem_data_q [FIFO_DEPTH];
  logic                    mem_last_q [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q;
  logic [PTR_W-1:0]        rd_ptr_q;
  logic [CNT_W-1:0]        count_q;
  logic [CNT_W-1:0]        count_d;
  logic                    accept;
  logic                    push;
  logic                    pop;

  // Every strobe is qualified by rdy, so rdy=0 freezes all state below.
  always_comb begin
    req_ready = rdy && (state_q == S_IDLE);
    ram_req   = rdy && (state_q == S_FETCH) && (count_q < C_DEPTH);
    ram_addr  = cur_addr_q;
    busy      = (state_q == S_FETCH);
    out_valid = rdy && (count_q != '0);
    out_data  = mem_data_q[rd_ptr_q];
    out_last  = mem_last_q[rd_ptr_q];
    accept    = req_valid && req_ready;
    push      = ram_req && ram_done;
    pop       = out_valid && out_ready;
    count_d   = count_q;
    if (push && !pop) begin
      count_d = count_q + C_CNT_ONE;
    end else if (pop && !push) begin
      count_d = count_q - C_CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_last_q[i] <= 1'b0;
      end
    end else begin
      count_q <= count_d;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
      end
      if (push) begin
        mem_data_q[wr_ptr_q] <= ram_data;
        mem_last_q[wr_ptr_q] <= (remaining_q == C_LEN_ONE);
        wr_ptr_q             <= wr_ptr_q + C_PTR_ONE;
      end
      case (state_q)
        S_IDLE: begin
          // A zero-length request is consumed without touching the RAM.
          if (accept && (req_len != '0)) begin
            cur_addr_q  <= req_addr;
            remaining_q <= req_len;
            state_q     <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (push) begin
            cur_addr_q  <= cur_addr_q + C_WORD_BYTES;
            remaining_q <= remaining_q - C_LEN_ONE;
            if (remaining_q == C_LEN_ONE) begin
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_burst_reader
// Brief    : Self-checking bench for ram_burst_reader: vector table plus
//            directed multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_burst_reader;

  localparam logic [31:0] C_KEY = 32'hC0DE_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic        ram_req;
  logic [31:0] ram_addr;
  wire  [31:0] ram_data;
  logic        ram_done;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  logic        use_model;
  logic [31:0] tb_data;

  int          nchecks = 0;
  int          nerr    = 0;
  int          ncomp   = 0;
  logic [32:0] got[$];

  // Model RAM: each word is its own address XOR a key.
  assign ram_data = use_model ? (ram_addr ^ C_KEY) : tb_data;

  ram_burst_reader #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .ram_req(ram_req), .ram_addr(ram_addr),
    .ram_data(ram_data), .ram_done(ram_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        rdy, req_valid;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic        ram_done;
    logic [31:0] ram_data;
    logic        out_ready;
    logic        e_req_ready, e_ram_req;
    logic [31:0] e_ram_addr;
    logic        e_busy, e_out_valid;
    logic [31:0] e_out_data;
    logic        e_out_last;
  } vec_t;

  function automatic vec_t mk(
    input logic rv, input logic [31:0] ra, input logic [7:0] rl,
    input logic rd, input logic [31:0] d,
    input logic erq, input logic err, input logic [31:0] ea,
    input logic eb, input logic ev, input logic [31:0] ed, input logic el);
    vec_t v;
    v.rdy = 1'b1; v.req_valid = rv; v.req_addr = ra; v.req_len = rl;
    v.ram_done = rd; v.ram_data = d; v.out_ready = 1'b1;
    v.e_req_ready = erq; v.e_ram_req = err; v.e_ram_addr = ea;
    v.e_busy = eb; v.e_out_valid = ev; v.e_out_data = ed; v.e_out_last = el;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    nchecks++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clk_step();
    if (out_valid && out_ready) got.push_back({out_last, out_data});
    if (ram_req && ram_done) ncomp++;
    @(posedge clk);
    #1;
  endtask

  task automatic request(input string name, input logic [31:0] a, input logic [7:0] n);
    req_valid = 1'b1; req_addr = a; req_len = n;
    settle();
    check({name, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    clk_step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 50; k++) begin
      settle();
      if (!busy && !out_valid) break;
      clk_step();
    end
    check({name, "_idle"}, {30'b0, busy, out_valid}, 32'd0);
    got.delete();
    ncomp = 0;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < 40 && got.size() < n; k++) begin
      settle();
      clk_step();
    end
  endtask

  task automatic check_burst(input string name, input logic [31:0] base, input int n);
    check({name, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++) begin
      check($sformatf("%s_data%0d", name, i), got[i][31:0], (base + 32'(4 * i)) ^ C_KEY);
      check($sformatf("%s_last%0d", name, i), {31'b0, got[i][32]}, {31'b0, (i == n - 1)});
    end
  endtask

  vec_t vecs[12];

  initial begin
    // Basic burst 0x100 x3, wrap burst 0xFFFFFFF8 x3, then a zero-length request.
    vecs[0]  = mk(1, 32'h100,      3, 0, 0,            1, 0, 32'h0,        0, 0, 0,            0);
    vecs[1]  = mk(0, 0,            0, 1, 32'h11111111, 0, 1, 32'h100,      1, 0, 0,            0);
    vecs[2]  = mk(0, 0,            0, 1, 32'h22222222, 0, 1, 32'h104,      1, 1, 32'h11111111, 0);
    vecs[3]  = mk(0, 0,            0, 1, 32'h33333333, 0, 1, 32'h108,      1, 1, 32'h22222222, 0);
    vecs[4]  = mk(0, 0,            0, 0, 0,            1, 0, 32'h10C,      0, 1, 32'h33333333, 1);
    vecs[5]  = mk(1, 32'hFFFFFFF8, 3, 0, 0,            1, 0, 32'h10C,      0, 0, 0,            0);
    vecs[6]  = mk(0, 0,            0, 1, 32'hA0A0A0A0, 0, 1, 32'hFFFFFFF8, 1, 0, 0,            0);
    vecs[7]  = mk(0, 0,            0, 1, 32'hA1A1A1A1, 0, 1, 32'hFFFFFFFC, 1, 1, 32'hA0A0A0A0, 0);
    vecs[8]  = mk(0, 0,            0, 1, 32'hA2A2A2A2, 0, 1, 32'h0,        1, 1, 32'hA1A1A1A1, 0);
    vecs[9]  = mk(1, 32'h200,      0, 1, 0,            1, 0, 32'h4,        0, 1, 32'hA2A2A2A2, 1);
    vecs[10] = mk(0, 0,            0, 1, 0,            1, 0, 32'h4,        0, 0, 0,            0);
    vecs[11] = mk(0, 0,            0, 1, 0,            1, 0, 32'h4,        0, 0, 0,            0);

    rst = 1'b1; rdy = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0;
    ram_done = 1'b0; out_ready = 1'b1; use_model = 1'b0; tb_data = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_ram_req",   {31'b0, ram_req},   32'd0);
    check("rst_ram_addr",  ram_addr,           32'h0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_busy",      {31'b0, busy},      32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      rdy = vecs[i].rdy; req_valid = vecs[i].req_valid; req_addr = vecs[i].req_addr;
      req_len = vecs[i].req_len; ram_done = vecs[i].ram_done; tb_data = vecs[i].ram_data;
      out_ready = vecs[i].out_ready;
      settle();
      check($sformatf("vec%0d_req_ready", i), {31'b0, req_ready}, {31'b0, vecs[i].e_req_ready});
      check($sformatf("vec%0d_ram_req", i),   {31'b0, ram_req},   {31'b0, vecs[i].e_ram_req});
      check($sformatf("vec%0d_ram_addr", i),  ram_addr,           vecs[i].e_ram_addr);
      check($sformatf("vec%0d_busy", i),      {31'b0, busy},      {31'b0, vecs[i].e_busy});
      check($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_out_valid});
      if (vecs[i].e_out_valid) begin
        check($sformatf("vec%0d_out_data", i), out_data,           vecs[i].e_out_data);
        check($sformatf("vec%0d_out_last", i), {31'b0, out_last},  {31'b0, vecs[i].e_out_last});
      end
      clk_step();
    end
    req_valid = 1'b0;
    use_model = 1'b1;
    wait_idle("table");

    // Backpressure: FIFO fills after four words, then ram_req resumes after one pop.
    out_ready = 1'b0; ram_done = 1'b1;
    request("bp", 32'h1000, 8'd8);
    for (int i = 0; i < 10; i++) begin
      settle();
      if (i == 3) check("bp_ram_req_before_full", {31'b0, ram_req}, 32'd1);
      if (i == 4) check("bp_ram_req_full",        {31'b0, ram_req}, 32'd0);
      clk_step();
    end
    check("bp_words_before_stall", ncomp, 4);
    out_ready = 1'b1;
    settle();
    check("bp_ram_req_first_pop", {31'b0, ram_req}, 32'd0);
    clk_step();
    settle();
    check("bp_ram_req_rise", {31'b0, ram_req}, 32'd1);
    clk_step();
    drain(8);
    check_burst("bp", 32'h1000, 8);
    wait_idle("bp");

    // RAM wait states on the second word.
    request("ws", 32'h300, 8'd3);
    ram_done = 1'b1; settle(); clk_step();
    ram_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      check($sformatf("ws_hold_addr%0d", i), ram_addr, 32'h304);
      check($sformatf("ws_hold_req%0d", i), {31'b0, ram_req}, 32'd1);
      clk_step();
    end
    ram_done = 1'b1;
    settle();
    check("ws_resume_addr", ram_addr, 32'h304);
    clk_step();
    drain(3);
    check_burst("ws", 32'h300, 3);
    wait_idle("ws");

    // rdy freeze mid-burst.
    request("fz", 32'h400, 8'd4);
    settle(); clk_step();
    settle(); clk_step();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("fz_ram_req%0d", i),   {31'b0, ram_req},   32'd0);
      check($sformatf("fz_out_valid%0d", i), {31'b0, out_valid}, 32'd0);
      check($sformatf("fz_req_ready%0d", i), {31'b0, req_ready}, 32'd0);
      check($sformatf("fz_addr%0d", i),      ram_addr,           32'h408);
      clk_step();
    end
    rdy = 1'b1;
    settle();
    check("fz_resume_addr", ram_addr, 32'h408);
    check("fz_resume_req",  {31'b0, ram_req}, 32'd1);
    drain(4);
    check_burst("fz", 32'h400, 4);
    wait_idle("fz");

    // Asynchronous reset after two of six words.
    out_ready = 1'b0; ram_done = 1'b1;
    request("rs", 32'h500, 8'd6);
    settle(); clk_step();
    settle(); clk_step();
    check("rs_pre_words", ncomp, 2);
    #2;
    rst = 1'b1;
    #1;
    check("rs_async_ram_req",   {31'b0, ram_req},   32'd0);
    check("rs_async_ram_addr",  ram_addr,           32'h0);
    check("rs_async_out_valid", {31'b0, out_valid}, 32'd0);
    check("rs_async_out_data",  out_data,           32'h0);
    check("rs_async_out_last",  {31'b0, out_last},  32'd0);
    check("rs_async_busy",      {31'b0, busy},      32'd0);
    check("rs_async_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      settle();
      check($sformatf("rs_post_out_valid%0d", i), {31'b0, out_valid}, 32'd0);
      check($sformatf("rs_post_req_ready%0d", i), {31'b0, req_ready}, 32'd1);
      check($sformatf("rs_post_ram_req%0d", i),   {31'b0, ram_req},   32'd0);
      clk_step();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
`default_nettype wire
